// File: rtl/spi_mc_pkg.sv
// Shared types for the multi-mode SPI master: FSM state encoding and the
// per-frame SPI mode captured when a frame starts.
package spi_mc_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

endpackage

// File: rtl/spi_mc_fifo.sv
// Synchronous FIFO with flush. A push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module spi_mc_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FullCnt);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_mc.sv
// SPI master with configurable frame width, all four CPOL/CPHA modes,
// LSB-first option, tx/rx FIFOs and an every-(icnt+1)-frames interrupt.
module spi_master_mc
  import spi_mc_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NUM_CS     = 4,
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned CNT_W      = 2,
  localparam int unsigned CsW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spe,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [CNT_W-1:0]  icnt,
  input  logic [CsW-1:0]    cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              irq_clr,
  output logic              irq_o,
  output logic              rx_overrun,
  output logic              busy,
  output logic              sck_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [NUM_CS-1:0] ss_n_o
);

  localparam int unsigned TogW = $clog2(2 * DATA_W);
  localparam logic [TogW-1:0] LastTog = TogW'(2 * DATA_W - 1);

  spi_state_e        state_q;
  spi_mode_t         mode_q;
  logic [DIV_W-1:0]  div_q, hcnt_q;
  logic [TogW-1:0]   tog_q;
  logic [DATA_W-1:0] treg_q, rreg_q;
  logic              sck_q, mosi_q, irq_q, ovr_q;
  logic [NUM_CS-1:0] ss_n_q;
  logic [CNT_W-1:0]  tcnt_q;

  logic [DATA_W-1:0] tx_head;
  logic              tx_full, tx_empty, tx_pop;
  logic              rx_full, rx_empty, rx_push, rx_pop;
  logic              leading;

  assign tx_pop  = spe && (state_q == StIdle) && !tx_empty;
  assign rx_push = spe && (state_q == StDone);
  assign rx_pop  = rx_ready && !rx_empty;
  // Edge parity: even toggles leave the idle level, odd ones return to it.
  assign leading = !tog_q[0];

  spi_mc_fifo #(
    .Width (DATA_W),
    .Depth (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (!spe),
    .push_i  (tx_valid),
    .pop_i   (tx_pop),
    .data_i  (tx_data),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  spi_mc_fifo #(
    .Width (DATA_W),
    .Depth (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (!spe),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .data_i  (rreg_q),
    .data_o  (rx_data),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      mode_q  <= '0;
      div_q   <= '0;
      hcnt_q  <= '0;
      tog_q   <= '0;
      treg_q  <= '0;
      rreg_q  <= '0;
      sck_q   <= cpol;
      mosi_q  <= 1'b0;
      ss_n_q  <= '1;
      irq_q   <= 1'b0;
      ovr_q   <= 1'b0;
      tcnt_q  <= icnt;
    end else if (!spe) begin
      state_q <= StIdle;
      sck_q   <= cpol;
      mosi_q  <= 1'b0;
      ss_n_q  <= '1;
      tcnt_q  <= icnt;
      if (irq_clr) begin
        irq_q <= 1'b0;
        ovr_q <= 1'b0;
      end
    end else begin
      // Clear first so that a set event later in this block wins.
      if (irq_clr) begin
        irq_q <= 1'b0;
        ovr_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          sck_q <= cpol;
          if (!tx_empty) begin
            state_q          <= StShift;
            mode_q.cpol      <= cpol;
            mode_q.cpha      <= cpha;
            mode_q.lsb_first <= lsb_first;
            div_q            <= clk_div;
            hcnt_q           <= clk_div;
            tog_q            <= '0;
            ss_n_q           <= ~(NUM_CS'(1) << cs_sel);
            if (!cpha) begin
              mosi_q <= lsb_first ? tx_head[0] : tx_head[DATA_W-1];
              treg_q <= lsb_first ? (tx_head >> 1) : (tx_head << 1);
            end else begin
              treg_q <= tx_head;
            end
          end
        end
        StShift: begin
          if (hcnt_q == '0) begin
            hcnt_q <= div_q;
            sck_q  <= ~sck_q;
            tog_q  <= tog_q + 1'b1;
            if (leading ^ mode_q.cpha) begin
              rreg_q <= mode_q.lsb_first ? {miso_i, rreg_q[DATA_W-1:1]}
                                         : {rreg_q[DATA_W-2:0], miso_i};
            end else if (tog_q != LastTog) begin
              mosi_q <= mode_q.lsb_first ? treg_q[0] : treg_q[DATA_W-1];
              treg_q <= mode_q.lsb_first ? (treg_q >> 1) : (treg_q << 1);
            end
            if (tog_q == LastTog) begin
              state_q <= StDone;
            end
          end else begin
            hcnt_q <= hcnt_q - 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          sck_q   <= mode_q.cpol;
          ss_n_q  <= '1;
          if (rx_full && !rx_pop) begin
            ovr_q <= 1'b1;
          end
          if (tcnt_q == '0) begin
            irq_q  <= 1'b1;
            tcnt_q <= icnt;
          end else begin
            tcnt_q <= tcnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_ready   = !tx_full;
  assign rx_valid   = !rx_empty;
  assign irq_o      = irq_q;
  assign rx_overrun = ovr_q;
  assign busy       = (state_q != StIdle);
  assign sck_o      = sck_q;
  assign mosi_o     = mosi_q;
  assign ss_n_o     = ss_n_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: framing, modes, irq counting, FIFO limits,
// abort and reset behaviour against hand-computed expectations.
module tb_spi_master_mc;

  logic       clk = 1'b0;
  logic       rst_i, spe, cpol, cpha, lsb_first;
  logic [7:0] clk_div;
  logic [1:0] icnt, cs_sel;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, irq_clr;
  logic       irq_o, rx_overrun, busy, sck_o, mosi_o, miso_i;
  logic [3:0] ss_n_o;
  logic       lb;
  logic [7:0] slv_sr;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  assign miso_i = lb ? mosi_o : slv_sr[7];

  spi_master_mc dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .spe        (spe),
    .cpol       (cpol),
    .cpha       (cpha),
    .lsb_first  (lsb_first),
    .clk_div    (clk_div),
    .icnt       (icnt),
    .cs_sel     (cs_sel),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .irq_clr    (irq_clr),
    .irq_o      (irq_o),
    .rx_overrun (rx_overrun),
    .busy       (busy),
    .sck_o      (sck_o),
    .mosi_o     (mosi_o),
    .miso_i     (miso_i),
    .ss_n_o     (ss_n_o)
  );

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  task automatic push_word(input logic [7:0] d);
    int g = 0;
    while (tx_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    vectors++;
    if (g >= 200) begin
      miscompares++;
      $display("FAIL push_timeout: tx_ready=%b after %0d cycles, want 1", tx_ready, g);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl);
    int g = 0;
    while (busy !== lvl && g < 400) begin
      @(negedge clk);
      g++;
    end
    vectors++;
    if (g >= 400) begin
      miscompares++;
      $display("FAIL busy_timeout: busy=%b, want %b", busy, lvl);
    end
  endtask

  task automatic wait_frame();
    wait_busy(1'b1);
    wait_busy(1'b0);
  endtask

  // Push one word and observe the frame; mseq collects mosi on sample edges.
  task automatic do_frame(input logic [7:0] d, output int cyc, output int edges,
                          output int ssl, output logic [7:0] mseq);
    logic sp;
    int   g;
    cyc = 0; edges = 0; ssl = 0; mseq = '0;
    push_word(d);
    sp = sck_o;
    g  = 0;
    while (g < 400) begin
      @(negedge clk);
      g++;
      if (busy === 1'b1) begin
        cyc++;
        if (ss_n_o[cs_sel] === 1'b0) ssl++;
      end
      if (sck_o !== sp) begin
        edges++;
        if ((sck_o != cpol) != cpha) mseq = {mseq[6:0], mosi_o};
        if (!lb && sck_o === cpol) slv_sr = {slv_sr[6:0], 1'b0};
        sp = sck_o;
      end
      if (cyc > 0 && busy === 1'b0) break;
    end
    vectors++;
    if (g >= 400) begin
      miscompares++;
      $display("FAIL frame_timeout: busy=%b cycles=%0d", busy, cyc);
    end
  endtask

  task automatic restart(input logic [1:0] ic);
    icnt    = ic;
    spe     = 1'b0;
    irq_clr = 1'b1;
    @(negedge clk);
    spe     = 1'b1;
    irq_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    vectors += 9;
    if (sck_o !== 1'b0) begin miscompares++; $display("FAIL rst_sck: got %b want 0", sck_o); end
    if (mosi_o !== 1'b0) begin miscompares++; $display("FAIL rst_mosi: got %b want 0", mosi_o); end
    if (ss_n_o !== 4'hF) begin miscompares++; $display("FAIL rst_ss: got %h want f", ss_n_o); end
    if (irq_o !== 1'b0) begin miscompares++; $display("FAIL rst_irq: got %b want 0", irq_o); end
    if (rx_overrun !== 1'b0) begin miscompares++; $display("FAIL rst_ovr: got %b want 0", rx_overrun); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL rst_txr: got %b want 1", tx_ready); end
    if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rxv: got %b want 0", rx_valid); end
    if (dut.tcnt_q !== 2'd0) begin miscompares++; $display("FAIL rst_tcnt: got %0d want 0", dut.tcnt_q); end
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mode0_frame();
    int cyc, edges, ssl;
    logic [7:0] mseq;
    cpol = 0; cpha = 0; lsb_first = 0; clk_div = 8'd1; cs_sel = 2'd2; lb = 0;
    spe = 1'b1;
    slv_sr = 8'h3C;
    do_frame(8'hA5, cyc, edges, ssl, mseq);
    vectors += 7;
    if (mseq !== 8'hA5) begin miscompares++; $display("FAIL m0_mosi: got %h want a5", mseq); end
    if (cyc != 33) begin miscompares++; $display("FAIL m0_len: got %0d want 33", cyc); end
    if (edges != 16) begin miscompares++; $display("FAIL m0_edges: got %0d want 16", edges); end
    if (ssl != 33) begin miscompares++; $display("FAIL m0_ss_low: got %0d want 33", ssl); end
    if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL m0_rxv: got %b want 1", rx_valid); end
    if (rx_data !== 8'h3C) begin miscompares++; $display("FAIL m0_rx: got %h want 3c", rx_data); end
    if (ss_n_o !== 4'hF) begin miscompares++; $display("FAIL m0_ss_end: got %h want f", ss_n_o); end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_modes();
    logic [3:0] cfg [4] = '{4'b0111, 4'b1011, 4'b1111, 4'b1110};
    logic [7:0] dat [4] = '{8'h81, 8'h81, 8'h81, 8'hC4};
    int cyc, edges, ssl;
    logic [7:0] mseq, exp_seq;
    lb = 1'b1; clk_div = 8'd0; cs_sel = 2'd1;
    for (int i = 0; i < 4; i++) begin
      cpol = cfg[i][3]; cpha = cfg[i][2]; lsb_first = cfg[i][1];
      @(negedge clk);
      do_frame(dat[i], cyc, edges, ssl, mseq);
      exp_seq = lsb_first ? rev8(dat[i]) : dat[i];
      vectors += 5;
      if (rx_data !== dat[i]) begin miscompares++; $display("FAIL mode%0d_rx: got %h want %h", i, rx_data, dat[i]); end
      if (mseq !== exp_seq) begin miscompares++; $display("FAIL mode%0d_mosi: got %h want %h", i, mseq, exp_seq); end
      if (sck_o !== cpol) begin miscompares++; $display("FAIL mode%0d_idle: got %b want %b", i, sck_o, cpol); end
      if (edges != 16) begin miscompares++; $display("FAIL mode%0d_edges: got %0d want 16", i, edges); end
      if (cyc != 17) begin miscompares++; $display("FAIL mode%0d_len: got %0d want 17", i, cyc); end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  task automatic test_irq_count();
    logic [1:0] exp_t [6] = '{2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2};
    logic       exp_i [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int cyc, edges, ssl;
    logic [7:0] mseq;
    cpol = 0; cpha = 0; lsb_first = 0; clk_div = 8'd0; lb = 1'b1;
    rx_ready = 1'b1;
    restart(2'd2);
    vectors += 2;
    if (dut.tcnt_q !== 2'd2) begin miscompares++; $display("FAIL irq_tcnt0: got %0d want 2", dut.tcnt_q); end
    if (irq_o !== 1'b0) begin miscompares++; $display("FAIL irq_clr0: got %b want 0", irq_o); end
    for (int i = 0; i < 6; i++) begin
      do_frame(8'h10 + 8'(i), cyc, edges, ssl, mseq);
      vectors += 2;
      if (irq_o !== exp_i[i]) begin miscompares++; $display("FAIL irq_f%0d: got %b want %b", i + 1, irq_o, exp_i[i]); end
      if (dut.tcnt_q !== exp_t[i]) begin miscompares++; $display("FAIL tcnt_f%0d: got %0d want %0d", i + 1, dut.tcnt_q, exp_t[i]); end
      if (i == 2) begin
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        vectors++;
        if (irq_o !== 1'b0) begin miscompares++; $display("FAIL irq_clr: got %b want 0", irq_o); end
      end
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [7:0] w [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    cpol = 0; cpha = 0; lsb_first = 0; clk_div = 8'd0; lb = 1'b1; rx_ready = 1'b0;
    restart(2'd3);
    for (int i = 0; i < 5; i++) begin
      tx_data  = w[i];
      tx_valid = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    vectors++;
    if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL tx_full: got %b want 0", tx_ready); end
    push_word(w[5]);
    for (int f = 2; f <= 6; f++) begin
      wait_frame();
      if (f == 4) begin
        vectors += 2;
        if (rx_overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_f4: got %b want 0", rx_overrun); end
        if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL rxv_f4: got %b want 1", rx_valid); end
      end
      if (f == 5) begin
        vectors++;
        if (rx_overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_f5: got %b want 1", rx_overrun); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rx_data !== w[i]) begin miscompares++; $display("FAIL rx_entry%0d: got %h want %h", i, rx_data, w[i]); end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    vectors++;
    if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL rx_drain: got %b want 0", rx_valid); end
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    vectors++;
    if (rx_overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_clr: got %b want 0", rx_overrun); end
  endtask

  task automatic test_abort();
    int cyc, edges, ssl;
    logic [7:0] mseq;
    cpol = 0; cpha = 0; lsb_first = 0; clk_div = 8'd1; lb = 1'b1; cs_sel = 2'd0;
    restart(2'd3);
    do_frame(8'h77, cyc, edges, ssl, mseq);
    vectors += 2;
    if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL ab_rxv_pre: got %b want 1", rx_valid); end
    if (dut.tcnt_q !== 2'd2) begin miscompares++; $display("FAIL ab_tcnt_pre: got %0d want 2", dut.tcnt_q); end
    push_word(8'h99);
    wait_busy(1'b1);
    repeat (12) @(negedge clk);
    push_word(8'h44);
    spe = 1'b0;
    @(negedge clk);
    vectors += 5;
    if (ss_n_o !== 4'hF) begin miscompares++; $display("FAIL ab_ss: got %h want f", ss_n_o); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL ab_busy: got %b want 0", busy); end
    if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL ab_rxv: got %b want 0", rx_valid); end
    if (dut.tcnt_q !== 2'd3) begin miscompares++; $display("FAIL ab_tcnt: got %0d want 3", dut.tcnt_q); end
    if (sck_o !== 1'b0) begin miscompares++; $display("FAIL ab_sck: got %b want 0", sck_o); end
    spe = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL ab_txflush: got busy %b want 0", busy); end
    do_frame(8'h5A, cyc, edges, ssl, mseq);
    vectors += 3;
    if (rx_data !== 8'h5A) begin miscompares++; $display("FAIL ab_rx: got %h want 5a", rx_data); end
    if (mseq !== 8'h5A) begin miscompares++; $display("FAIL ab_mosi: got %h want 5a", mseq); end
    if (ssl != 33) begin miscompares++; $display("FAIL ab_ss_low: got %0d want 33", ssl); end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int cyc, edges, ssl;
    logic [7:0] mseq;
    cpol = 1; cpha = 1; lsb_first = 0; clk_div = 8'd1; lb = 1'b1;
    rx_ready = 1'b1;
    restart(2'd0);
    do_frame(8'hFF, cyc, edges, ssl, mseq);
    vectors++;
    if (irq_o !== 1'b1) begin miscompares++; $display("FAIL rm_irq_pre: got %b want 1", irq_o); end
    push_word(8'hFF);
    wait_busy(1'b1);
    repeat (6) @(negedge clk);
    vectors++;
    if (mosi_o !== 1'b1) begin miscompares++; $display("FAIL rm_mosi_pre: got %b want 1", mosi_o); end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    vectors += 8;
    if (sck_o !== 1'b1) begin miscompares++; $display("FAIL rm_sck: got %b want 1", sck_o); end
    if (mosi_o !== 1'b0) begin miscompares++; $display("FAIL rm_mosi: got %b want 0", mosi_o); end
    if (ss_n_o !== 4'hF) begin miscompares++; $display("FAIL rm_ss: got %h want f", ss_n_o); end
    if (irq_o !== 1'b0) begin miscompares++; $display("FAIL rm_irq: got %b want 0", irq_o); end
    if (rx_overrun !== 1'b0) begin miscompares++; $display("FAIL rm_ovr: got %b want 0", rx_overrun); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rm_busy: got %b want 0", busy); end
    if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL rm_txr: got %b want 1", tx_ready); end
    if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL rm_rxv: got %b want 0", rx_valid); end
    rx_ready = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; spe = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    clk_div = 8'd1; icnt = 2'd0; cs_sel = 2'd0; tx_data = '0; tx_valid = 1'b0;
    rx_ready = 1'b0; irq_clr = 1'b0; lb = 1'b0; slv_sr = '0;
    @(negedge clk);
    test_reset();
    test_mode0_frame();
    test_modes();
    test_irq_count();
    test_fifo_full();
    test_abort();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_master_mc.md
Name: spi_master_mc

Overview:
Parametrised successor to the existing single-mode SPI core. It is an SPI master with configurable frame width, FIFO depth, chip-select count, all four CPOL/CPHA modes and LSB-first shifting. It keeps the interrupt-count scheme: the IRQ fires after icnt+1 completed frames. It sits between the host register block (valid/ready streams) and the SPI pins.

Parameters:
DATA_W, 8, frame width in bits (4..32)
FIFO_DEPTH, 4, entries in each of the tx and rx FIFOs (power of two, >=2)
NUM_CS, 4, number of active-low slave selects
DIV_W, 8, width of the SCK half-period divider
CNT_W, 2, width of icnt/tcnt

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-high reset
spe  in  1  core enable; low aborts and flushes
cpol  in  1  SCK idle level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
lsb_first  in  1  shift order
clk_div  in  DIV_W  SCK half period = clk_div+1 clk_i cycles
icnt  in  CNT_W  frames per IRQ minus 1
cs_sel  in  $clog2(NUM_CS)  slave to select
tx_data  in  DATA_W  write data
tx_valid  in  1  write strobe
tx_ready  out  1  tx FIFO not full
rx_data  out  DATA_W  rx FIFO head
rx_valid  out  1  rx FIFO not empty
rx_ready  in  1  pop rx FIFO
irq_clr  in  1  clear irq_o and rx_overrun
irq_o  out  1  sticky interrupt
rx_overrun  out  1  sticky; a frame was dropped because the rx FIFO was full
busy  out  1  state != IDLE
sck_o  out  1  SPI clock
mosi_o  out  1  SPI data out
miso_i  in  1  SPI data in
ss_n_o  out  NUM_CS  active-low selects

Behaviour:
- Reset values: all FIFOs empty, state=IDLE, sck_o=cpol, mosi_o=0, ss_n_o=all 1, irq_o=0, rx_overrun=0, tcnt=icnt, busy=0, tx_ready=1, rx_valid=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT: on the edge after spe=1 and tx FIFO non-empty.
  - Pop the tx head into treg.
  - Latch cpol, cpha, lsb_first, cs_sel and clk_div; changes mid-frame are ignored.
  - ss_n_o[cs_sel]=0; hcnt=clk_div; bcnt=DATA_W.
  - CPHA=0: mosi_o takes the first bit on entry.
- SHIFT:
  - hcnt counts down; at 0 it reloads and sck_o toggles.
  - Sample edge: miso_i is shifted into rreg.
  - Shift edge: mosi_o takes the next bit. Under CPHA=1 the leading edge drives the first bit.
  - bcnt decrements on each sample edge.
  - After 2*DATA_W toggles → DONE, with sck_o back at cpol.
- DONE (1 cycle):
  - Push rreg into the rx FIFO if not full; otherwise drop it and set rx_overrun.
  - ss_n_o goes all 1.
  - tcnt update: if tcnt==0, set irq_o and reload tcnt=icnt; else tcnt=tcnt-1, modulo 2^CNT_W.
  - → IDLE. At least one IDLE cycle separates frames, so ss_n_o toggles between frames.
- Frame length: 2*DATA_W*(clk_div+1)+1 cycles from SHIFT entry to return to IDLE.
- LSB-first: bit 0 goes out first and the received bit lands at the MSB end, shifting right. MSB-first mirrors this.
- tx FIFO:
  - A push with tx_valid=1 while full is ignored.
  - A simultaneous push and pop on a full FIFO is accepted.
- rx FIFO:
  - Pop on rx_valid&&rx_ready.
  - A pop and a DONE push in the same cycle on a full FIFO both succeed; no overrun.
- irq_clr:
  - Clears irq_o and rx_overrun.
  - If it coincides with a set event, the set wins.
- spe=0 (any state, including mid-frame):
  - Next edge: state=IDLE, ss_n_o all 1, sck_o=cpol, both FIFOs flushed, tcnt=icnt.
  - irq_o and rx_overrun are held.
- icnt written mid-count takes effect at the next reload.
- rst_i overrides everything, including mid-frame.

Decomposition:
- Package spi_mc_pkg: state enum (IDLE/SHIFT/DONE) and a mode struct {cpol, cpha, lsb_first}.
- Sub-module spi_mc_fifo: sync FIFO parameterised by width and depth, with push/pop/full/empty/flush. Instantiated twice.

Test Plan:
1. DATA_W=8, mode 0, clk_div=1, push 0xA5, slave returns 0x3C → mosi sequence 1,0,1,0,0,1,0,1; rx_data=0x3C; frame takes 33 cycles; 16 sck_o edges; ss_n_o[cs_sel] low throughout.
2. Modes 1/2/3 plus lsb_first=1, push 0x81 against a loopback slave → rx_data=0x81 and sck_o idle level equals cpol in every case.
3. icnt=2, push 6 frames → irq_o rises at the DONE of frames 3 and 6 (after irq_clr in between); tcnt sequence 2,1,0,2,1,0.
4. FIFO_DEPTH=4, push 6 words with no rx pops → tx_ready low after 4 outstanding; 4 rx entries; rx_overrun=1 after frame 5.
5. Drop spe to 0 at bit 3 of a frame → next cycle ss_n_o=all 1, busy=0, rx_valid=0, tcnt=icnt; re-enable and push → clean frame.
6. Assert rst_i mid-SHIFT with irq_o=1 → all outputs return to their reset values on the next edge.
